// File: rtl/l2_line_adaptor_pkg.sv
// Shared types for the L2 line adaptor: FSM state encoding and beat-count constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l2_adaptor_types;

  // Beats per cache line and the width of the beat index.
  localparam int n_beats    = 4;
  localparam int s_beat_idx = $clog2(n_beats);

  // Adaptor FSM states.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    HOLD
  } state_e;

endpackage

// File: rtl/l2_line_adaptor.sv
// Converts L2 256-bit line read/write requests into 4-beat 64-bit memory bursts and
// answers with a one-cycle completion pulse.
// Latency: request seen -> line_resp_o in 5 cycles minimum; one beat per burst_resp_i.
// Backpressure: burst beats advance only on burst_resp_i; L2 requests are level-held
// until line_resp_o, and a HOLD cycle stops a still-asserted request from being re-taken.
// Ports:
//   clk, rst                          clock, async active-high reset
//   line_read_i/line_write_i          L2 requests (level)
//   line_address_i/line_wdata_i       L2 line address and write line
//   line_rdata_o/line_resp_o          assembled read line, completion pulse
//   burst_read_o/burst_write_o        memory burst requests
//   burst_address_o/burst_wdata_o     line-aligned address, current write beat
//   burst_rdata_i/burst_resp_i        current read beat, beat-done strobe
module l2_line_adaptor
  import l2_adaptor_types::*;
#(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [31:0]        line_address_i,
  input  logic [s_line-1:0]  line_wdata_i,
  output logic [s_line-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic               burst_read_o,
  output logic               burst_write_o,
  output logic [31:0]        burst_address_o,
  output logic [s_burst-1:0] burst_wdata_o,
  input  logic [s_burst-1:0] burst_rdata_i,
  input  logic               burst_resp_i
);

  // Byte-offset bits within a line are cleared on the latched address.
  localparam logic [31:0] line_off_mask = 32'(s_line / 8 - 1);
  localparam logic [s_beat_idx-1:0] last_beat = s_beat_idx'(n_beats - 1);

  state_e                  state_q, state_d;
  logic [s_beat_idx-1:0]   cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [s_line-1:0]       wline_q, wline_d;
  logic [s_line-1:0]       rline_q, rline_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        // Write wins when both requests are present.
        if (line_write_i) begin
          addr_d  = line_address_i & ~line_off_mask;
          wline_d = line_wdata_i;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (line_read_i) begin
          addr_d  = line_address_i & ~line_off_mask;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (burst_resp_i) begin
          rline_d[cnt_q*s_burst +: s_burst] = burst_rdata_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) state_d = RESP;
        end
      end
      WRITE: begin
        if (burst_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) state_d = RESP;
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs come from state or registers only.
  assign burst_read_o    = (state_q == READ);
  assign burst_write_o   = (state_q == WRITE);
  assign line_resp_o     = (state_q == RESP);
  assign burst_address_o = addr_q;
  assign line_rdata_o    = rline_q;
  assign burst_wdata_o   = (state_q == WRITE) ? wline_q[cnt_q*s_burst +: s_burst] : '0;

endmodule

// File: tb/tb_l2_line_adaptor.sv
module tb_l2_line_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read_i, line_write_i;
  logic [31:0]  line_address_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic         burst_read_o, burst_write_o;
  logic [31:0]  burst_address_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_resp_i;

  int errors = 0;
  int checks = 0;

  // Reference: the read line the L2 should currently see.
  logic [255:0] model_line;
  logic [63:0]  bt [4];
  int           gp [4];

  always #5 clk = ~clk;

  l2_line_adaptor dut (
    .clk             (clk),
    .rst             (rst),
    .line_read_i     (line_read_i),
    .line_write_i    (line_write_i),
    .line_address_i  (line_address_i),
    .line_wdata_i    (line_wdata_i),
    .line_rdata_o    (line_rdata_o),
    .line_resp_o     (line_resp_o),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_address_o (burst_address_o),
    .burst_wdata_o   (burst_wdata_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i)
  );

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete transfer starting in an IDLE cycle (cycle 0), driven at negedges.
  // gp[b] idle cycles precede beat b. Request is held through RESP and HOLD, then dropped.
  task automatic do_xfer(input bit wr, input bit both, input logic [31:0] addr,
                         input logic [255:0] wl, input string nm);
    logic [31:0] exp_addr;
    bit          exp_rd;
    int          cyc;
    exp_addr = {addr[31:5], 5'b0};
    exp_rd   = !wr;
    line_write_i   = wr;
    line_read_i    = !wr || both;
    line_address_i = addr;
    line_wdata_i   = wl;
    burst_resp_i   = 1'b0;
    cyc = 0;
    @(negedge clk);
    cyc++;
    // Scramble request data; the adaptor must work from its latched copies.
    line_address_i = $urandom;
    line_wdata_i   = rand256();
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g <= gp[b]; g++) begin
        burst_resp_i  = (g == gp[b]);
        burst_rdata_i = (g == gp[b]) ? bt[b] : rand64();
        checks++;
        if (burst_read_o !== exp_rd || burst_write_o !== !exp_rd) begin
          errors++;
          $display("FAIL %s burst_req cyc%0d beat%0d: rd=%b wr=%b required rd=%b wr=%b",
                   nm, cyc, b, burst_read_o, burst_write_o, exp_rd, !exp_rd);
        end
        checks++;
        if (burst_address_o !== exp_addr || line_resp_o !== 1'b0) begin
          errors++;
          $display("FAIL %s addr/resp cyc%0d: addr=%h resp=%b required addr=%h resp=0",
                   nm, cyc, burst_address_o, line_resp_o, exp_addr);
        end
        if (wr) begin
          checks++;
          if (burst_wdata_o !== wl[64*b +: 64]) begin
            errors++;
            $display("FAIL %s wdata beat%0d cyc%0d: got %h required %h",
                     nm, b, cyc, burst_wdata_o, wl[64*b +: 64]);
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    // Response cycle; stray beat strobes here must be ignored.
    burst_resp_i  = 1'b1;
    burst_rdata_i = rand64();
    if (!wr) model_line = {bt[3], bt[2], bt[1], bt[0]};
    checks++;
    if (line_resp_o !== 1'b1 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0) begin
      errors++;
      $display("FAIL %s resp cyc%0d: resp=%b rd=%b wr=%b required resp=1 rd=0 wr=0",
               nm, cyc, line_resp_o, burst_read_o, burst_write_o);
    end
    checks++;
    if (line_rdata_o !== model_line || burst_address_o !== exp_addr) begin
      errors++;
      $display("FAIL %s rdata: got %h addr %h required %h addr %h",
               nm, line_rdata_o, burst_address_o, model_line, exp_addr);
    end
    @(negedge clk);
    cyc++;
    // HOLD: request still asserted.
    checks++;
    if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0) begin
      errors++;
      $display("FAIL %s hold cyc%0d: resp=%b rd=%b wr=%b required all 0",
               nm, cyc, line_resp_o, burst_read_o, burst_write_o);
    end
    @(negedge clk);
    cyc++;
    // Back in IDLE; the held request must not have been re-accepted.
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    burst_resp_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0
          || line_rdata_o !== model_line) begin
        errors++;
        $display("FAIL %s idle cyc%0d: resp=%b rd=%b wr=%b rdata=%h required 0/0/0/%h",
                 nm, cyc, line_resp_o, burst_read_o, burst_write_o, line_rdata_o, model_line);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line_read_i = 1'b0; line_write_i = 1'b0;
    line_address_i = '0; line_wdata_i = '0;
    burst_rdata_i = '0; burst_resp_i = 1'b0;
    model_line = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (line_rdata_o !== '0 || line_resp_o !== 1'b0 || burst_read_o !== 1'b0 ||
        burst_write_o !== 1'b0 || burst_address_o !== '0 || burst_wdata_o !== '0) begin
      errors++;
      $display("FAIL reset_values: rdata=%h resp=%b rd=%b wr=%b addr=%h wdata=%h required all 0",
               line_rdata_o, line_resp_o, burst_read_o, burst_write_o, burst_address_o, burst_wdata_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_zero_wait();
    bt[0] = 64'h1111_1111_1111_1111; bt[1] = 64'h2222_2222_2222_2222;
    bt[2] = 64'h3333_3333_3333_3333; bt[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) gp[i] = 0;
    do_xfer(1'b0, 1'b0, 32'h0000_1234, '0, "read_zero_wait");
  endtask

  task automatic test_write_gaps();
    logic [255:0] wl;
    wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    // Beats accepted in cycles 2, 5, 6, 9 -> response in cycle 10.
    gp[0] = 1; gp[1] = 2; gp[2] = 0; gp[3] = 2;
    for (int i = 0; i < 4; i++) bt[i] = rand64();
    do_xfer(1'b1, 1'b0, 32'h8000_0040, wl, "write_gaps");
  endtask

  task automatic test_both_requests();
    for (int i = 0; i < 4; i++) begin bt[i] = rand64(); gp[i] = i % 2; end
    do_xfer(1'b1, 1'b1, 32'h0000_ABCD, rand256(), "both_requests");
  endtask

  task automatic test_reset_mid_burst();
    line_read_i = 1'b1;
    line_address_i = 32'h0000_5000;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      burst_resp_i = 1'b1;
      burst_rdata_i = rand64();
      @(negedge clk);
    end
    burst_resp_i = 1'b0;
    rst = 1'b1;
    line_read_i = 1'b0;
    #1;
    checks++;
    if (line_rdata_o !== '0 || line_resp_o !== 1'b0 || burst_read_o !== 1'b0 ||
        burst_write_o !== 1'b0 || burst_address_o !== '0 || burst_wdata_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_burst: rdata=%h resp=%b rd=%b wr=%b addr=%h wdata=%h required all 0",
               line_rdata_o, line_resp_o, burst_read_o, burst_write_o, burst_address_o, burst_wdata_o);
    end
    model_line = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      burst_resp_i = $urandom_range(0, 1);
      burst_rdata_i = rand64();
      @(negedge clk);
      checks++;
      if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || line_rdata_o !== '0) begin
        errors++;
        $display("FAIL post_reset_quiet cyc%0d: resp=%b rd=%b rdata=%h required 0/0/0",
                 i, line_resp_o, burst_read_o, line_rdata_o);
      end
    end
    burst_resp_i = 1'b0;
    for (int i = 0; i < 4; i++) begin bt[i] = rand64(); gp[i] = 0; end
    do_xfer(1'b0, 1'b0, 32'h0000_5010, '0, "read_after_reset");
  endtask

  task automatic test_spurious_resp();
    for (int i = 0; i < 3; i++) begin
      burst_resp_i = 1'b1;
      burst_rdata_i = rand64();
      @(negedge clk);
    end
    burst_resp_i = 1'b0;
    for (int i = 0; i < 4; i++) begin bt[i] = rand64(); gp[i] = $urandom_range(0, 1); end
    do_xfer(1'b0, 1'b0, 32'hFFFF_FFFF, '0, "spurious_then_read");
  endtask

  task automatic test_back_to_back_random();
    bit wr;
    for (int n = 0; n < 8; n++) begin
      wr = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++) begin bt[i] = rand64(); gp[i] = $urandom_range(0, 3); end
      do_xfer(wr, 1'b0, $urandom, rand256(), wr ? "rand_write" : "rand_read");
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_gaps();
    test_both_requests();
    test_reset_mid_burst();
    test_spurious_resp();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
